async_elastic_fifo: RTL

Parametrised elastic buffer for the async req/ack dataflow fabric. It replaces chains of single-entry reg operators used for path balancing with one DEPTH-entry FIFO stage. It supports OUTPUT_SIZE consumers that each drain independently. An entry retires only after every consumer has taken it.

---
 rtl/async_fifo_pkg.sv | 29 ++
 rtl/async_fifo_rd_port.sv | 49 ++++
 rtl/async_elastic_fifo.sv | 112 +++++++++++
 3 files changed

// File: rtl/async_fifo_pkg.sv
// Shared helpers for async_elastic_fifo: width functions, upstream handshake states,
// wrap-by-compare pointer increment and the occupancy max-reduction step.
package async_fifo_pkg;

   typedef enum logic {
      UP_IDLE = 1'b0,
      UP_REQ  = 1'b1
   } up_state_t;

   typedef logic [31:0] stat_cnt_t;

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Wraps by explicit compare so non-power-of-two depths index correctly.
   function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int depth);
      return (ptr == 32'(depth - 1)) ? 32'd0 : ptr + 32'd1;
   endfunction

   function automatic logic [31:0] cnt_max(input logic [31:0] acc, input logic [31:0] val);
      return (val > acc) ? val : acc;
   endfunction

endpackage

// File: rtl/async_fifo_rd_port.sv
// One consumer port of async_elastic_fifo: private read pointer, unread counter,
// single-cycle ack and held output token.
module async_fifo_rd_port
   import async_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic                      req,
   input  logic [DATA_WIDTH-1:0]     rd_data,
   output logic                      ack,
   output logic [DATA_WIDTH-1:0]     dout,
   output logic [ptr_w(DEPTH)-1:0]   rptr,
   output logic [cnt_w(DEPTH)-1:0]   unread
);

   localparam int PTR_W = ptr_w(DEPTH);
   localparam int CNT_W = cnt_w(DEPTH);

   logic rd_en;

   // A high ack blocks the next read, which spaces transfers by an idle cycle.
   assign rd_en = req && !ack && (unread != '0);

   // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         ack    <= 1'b0;
         dout   <= '0;
         rptr   <= '0;
         unread <= '0;
      end else begin
         ack <= rd_en;
         if (rd_en) begin
            dout <= rd_data;
            rptr <= PTR_W'(ptr_inc(32'(rptr), DEPTH));
         end
         case ({wr_en, rd_en})
            2'b10:   unread <= unread + CNT_W'(1);
            2'b01:   unread <= unread - CNT_W'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/async_elastic_fifo.sv
// DEPTH-entry elastic buffer with one req/ack producer and OUTPUT_SIZE independent consumers.
// Define ASYNC_FIFO_STATS_EN to add the high_water and stall_cycles statistics outputs.
module async_elastic_fifo
   import async_fifo_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 4,
   parameter int OUTPUT_SIZE = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   output logic                              req_l,
   input  logic                              ack_l,
   input  logic [DATA_WIDTH-1:0]             din,
   input  logic [OUTPUT_SIZE-1:0]            req_r,
   output logic [OUTPUT_SIZE-1:0]            ack_r,
   output logic [DATA_WIDTH*OUTPUT_SIZE-1:0] dout,
   output logic [cnt_w(DEPTH)-1:0]           count
`ifdef ASYNC_FIFO_STATS_EN
   ,
   output logic [cnt_w(DEPTH)-1:0]           high_water,
   output stat_cnt_t                         stall_cycles
`endif
);

   localparam int PTR_W = ptr_w(DEPTH);
   localparam int CNT_W = cnt_w(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wptr;
   logic [PTR_W-1:0]      rptr   [OUTPUT_SIZE];
   logic [CNT_W-1:0]      unread [OUTPUT_SIZE];
   logic [CNT_W-1:0]      occ;
   logic                  wr_en;
   logic                  full;
   up_state_t             up_state, up_next;

   assign wr_en = req_l & ack_l;

   // Occupancy is set by the slowest consumer; the outstanding request holds a reserved slot.
   always_comb begin
      occ = '0;
      for (int k = 0; k < OUTPUT_SIZE; k++) begin
         occ = CNT_W'(cnt_max(32'(occ), 32'(unread[k])));
      end
   end

   assign count = occ;
   assign full  = (32'(occ) + 32'(req_l)) == 32'(DEPTH);

   always_ff @(posedge clk) begin
      if (rst) up_state <= UP_IDLE;
      else     up_state <= up_next;
   end

   // NOTE: next-state takes its default first so no path through the case leaves it unassigned.
   always_comb begin
      up_next = up_state;
      case (up_state)
         UP_IDLE: if (!ack_l && !full) up_next = UP_REQ;
         UP_REQ:  if (ack_l)           up_next = UP_IDLE;
         default:                      up_next = UP_IDLE;
      endcase
   end

   assign req_l = (up_state == UP_REQ);

   always_ff @(posedge clk) begin
      if (rst)        wptr <= '0;
      else if (wr_en) wptr <= PTR_W'(ptr_inc(32'(wptr), DEPTH));
   end

   // NOTE: storage is not reset; the cleared unread counters keep stale entries from ever being read.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) mem[wptr] <= din;
   end

   for (genvar k = 0; k < OUTPUT_SIZE; k++) begin : g_rd
      async_fifo_rd_port #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (DEPTH)
      ) u_rd_port (
         .clk     (clk),
         .rst     (rst),
         .wr_en   (wr_en),
         .req     (req_r[k]),
         .rd_data (mem[rptr[k]]),
         .ack     (ack_r[k]),
         .dout    (dout[k*DATA_WIDTH +: DATA_WIDTH]),
         .rptr    (rptr[k]),
         .unread  (unread[k])
      );
   end

`ifdef ASYNC_FIFO_STATS_EN
   logic [CNT_W-1:0] hw_q;

   always_ff @(posedge clk) begin
      if (rst) hw_q <= '0;
      else     hw_q <= (occ > hw_q) ? occ : hw_q;
   end

   assign high_water = (occ > hw_q) ? occ : hw_q;

   // Counts producer-blocked cycles, holding at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst)                                     stall_cycles <= '0;
      else if (full && !req_l && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
   end
`endif

endmodule
